cordic_controller: RTL and testbench
====================================

CORDIC_CONTROLLER -- requirements
Module: cordic_controller

Interface
REQ-001 Parameter WORD_LENGTH, default 16, datapath word width; carried for consistency only, no port depends on it.
REQ-002 Parameter ITERATIONS, default 16, number of micro-rotations per operation; legal range 2..WORD_LENGTH.
REQ-003 Derived constant ITER_W = clog2(ITERATIONS), width of the iteration index.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one vectoring operation; sampled only in IDLE.
REQ-007 busy  output  1  operation in progress (LOAD, PREROT, ITER).
REQ-008 done  output  1  one-cycle pulse; z result in datapath valid.
REQ-009 load_x, load_y, load_z  output  1 each  datapath register load enables.
REQ-010 load_d0  output  1  capture initial quadrant/sign bit.
REQ-011 load_d  output  1  capture per-iteration rotation direction bit.
REQ-012 sel_x, sel_y, sel_z  output  2 each  datapath mux selects: 0 = external input, 1 = pre-rotation path, 2 = ALU iteration path; 3 never driven.
REQ-013 clear_z  output  1  synchronous clear of phase register.
REQ-014 iter  output  ITER_W  current iteration index; shift amount and arctan-table index for datapath.

Function
REQ-015 States SHALL be IDLE, LOAD, PREROT, ITER, DONE; Moore outputs decoded only from registered state and counter, with no combinational path from start to any output.
REQ-016 IDLE: all enables, clear_z, busy, done = 0; sel_* = 0; iter = 0; start=1 -> LOAD, else stay.
REQ-017 LOAD (1 cycle): load_x = load_y = load_d0 = clear_z = 1, sel_x = sel_y = 0, busy = 1; -> PREROT.
REQ-018 PREROT (1 cycle): load_x = load_y = load_z = load_d = 1, sel_x = sel_y = sel_z = 1, busy = 1; counter cleared to 0; -> ITER.
REQ-019 ITER: load_x = load_y = load_z = load_d = 1, sel_x = sel_y = sel_z = 2, busy = 1, iter = counter; counter increments by 1 each cycle.
REQ-020 ITER with iter == ITERATIONS-1 -> DONE; counter never wraps or exceeds ITERATIONS-1.
REQ-021 DONE (1 cycle): done = 1, busy = 0, all enables 0, sel_* = 0; -> IDLE unconditionally.
REQ-022 Latency: start high in IDLE at cycle 0 -> done high in cycle ITERATIONS+3 (cycle 19 at default), busy high cycles 1..ITERATIONS+2.
REQ-023 start while busy or in DONE SHALL be ignored; no queuing.
REQ-024 start held high continuously SHALL produce back-to-back operations, each starting in the IDLE cycle after DONE.
REQ-025 Exactly one load_d0 pulse and exactly ITERATIONS+1 load_d pulses per operation.

Reset
REQ-026 rst low SHALL force IDLE, counter = 0, and all outputs to 0 immediately, independent of clk.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse; first start after release begins a fresh operation.
REQ-028 Release of rst SHALL take effect synchronously; first state change earliest on the rising edge after release.

Structure
REQ-029 Package cordic_pkg SHALL hold the state enumeration, SEL_INPUT = 0, SEL_PREROT = 1, SEL_ITER = 2, shared with the datapath.
REQ-030 Iteration counter SHALL be a sub-module cordic_iter_counter (clear, enable, terminal-count output, parameter ITERATIONS).
REQ-031 Target size 120-250 lines of RTL including the sub-module.

Verification
REQ-032 Default params, start pulse at cycle 0 -> busy cycles 1..18, iter 0..15 in cycles 3..18, done only in cycle 19.
REQ-033 start pulsed in cycles 5 and 18 during an operation -> ignored; exactly one done; outputs identical to REQ-032.
REQ-034 rst driven low between clock edges in cycle 10 -> all outputs 0 at once; no done; new start after release -> done 19 cycles later.
REQ-035 start held high for 60 cycles -> done in cycles 19, 39, 59; one IDLE cycle between operations.
REQ-036 ITERATIONS = 2 -> iter 0,1 in cycles 3,4; done in cycle 5; load_d pulses = 3, load_d0 pulses = 1.
REQ-037 All runs: sel_* never 3; clear_z only in LOAD; load_z never in LOAD.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC vectoring controller and its datapath:
// FSM state encoding and the datapath mux select codes.
package cordic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PREROT,
      ST_ITER,
      ST_DONE
   } cordic_state_e;

   localparam logic [1:0] SEL_INPUT  = 2'd0;
   localparam logic [1:0] SEL_PREROT = 2'd1;
   localparam logic [1:0] SEL_ITER   = 2'd2;

endpackage

// File: rtl/cordic_iter_counter.sv
// Micro-rotation index counter: cleared before the first iteration, advances
// while enabled and saturates at ITERATIONS-1, flagged by the terminal count.
module cordic_iter_counter #(
   parameter int ITERATIONS = 16,
   parameter int ITER_W     = $clog2(ITERATIONS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              enable_i,
   output logic [ITER_W-1:0] count_o,
   output logic              tc_o
);

   localparam logic [ITER_W-1:0] LAST = ITER_W'(ITERATIONS - 1);

   logic [ITER_W-1:0] count_q;
   logic [ITER_W-1:0] count_d;

   assign tc_o    = (count_q == LAST);
   assign count_o = count_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !tc_o) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cordic_controller.sv
// Control FSM for an iterative CORDIC vectoring unit: sequences load,
// quadrant pre-rotation and ITERATIONS micro-rotations, then pulses done.
module cordic_controller
   import cordic_pkg::*;
#(
   parameter int WORD_LENGTH = 16,
   parameter int ITERATIONS  = 16,
   localparam int ITER_W     = $clog2(ITERATIONS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              load_x,
   output logic              load_y,
   output logic              load_z,
   output logic              load_d0,
   output logic              load_d,
   output logic [1:0]        sel_x,
   output logic [1:0]        sel_y,
   output logic [1:0]        sel_z,
   output logic              clear_z,
   output logic [ITER_W-1:0] iter
);

   generate
      if (ITERATIONS < 2 || ITERATIONS > WORD_LENGTH) begin : g_bad_params
         $error("cordic_controller: ITERATIONS must lie in 2..WORD_LENGTH");
      end
   endgenerate

   cordic_state_e     state_q;
   logic [ITER_W-1:0] count;
   logic              count_tc;

   cordic_iter_counter #(
      .ITERATIONS (ITERATIONS),
      .ITER_W     (ITER_W)
   ) u_iter_counter (
      .clk      (clk),
      .rst_n    (rst),
      .clear_i  (state_q == ST_PREROT),
      .enable_i (state_q == ST_ITER),
      .count_o  (count),
      .tc_o     (count_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start) state_q <= ST_LOAD;
            ST_LOAD:   state_q <= ST_PREROT;
            ST_PREROT: state_q <= ST_ITER;
            ST_ITER:   if (count_tc) state_q <= ST_DONE;
            ST_DONE:   state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   // Moore decode from the registered state only; start never reaches an output.
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      load_x  = 1'b0;
      load_y  = 1'b0;
      load_z  = 1'b0;
      load_d0 = 1'b0;
      load_d  = 1'b0;
      sel_x   = SEL_INPUT;
      sel_y   = SEL_INPUT;
      sel_z   = SEL_INPUT;
      clear_z = 1'b0;
      iter    = '0;
      case (state_q)
         ST_LOAD: begin
            busy    = 1'b1;
            load_x  = 1'b1;
            load_y  = 1'b1;
            load_d0 = 1'b1;
            clear_z = 1'b1;
         end
         ST_PREROT: begin
            busy   = 1'b1;
            load_x = 1'b1;
            load_y = 1'b1;
            load_z = 1'b1;
            load_d = 1'b1;
            sel_x  = SEL_PREROT;
            sel_y  = SEL_PREROT;
            sel_z  = SEL_PREROT;
         end
         ST_ITER: begin
            busy   = 1'b1;
            load_x = 1'b1;
            load_y = 1'b1;
            load_z = 1'b1;
            load_d = 1'b1;
            sel_x  = SEL_ITER;
            sel_y  = SEL_ITER;
            sel_z  = SEL_ITER;
            iter   = count;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cordic_controller.sv
// Self-checking bench: two controller instances (ITERATIONS 16 and 2) share
// stimulus and are compared every cycle against a schedule-level model.
module tb_cordic_controller;

   localparam int N_A = 16;
   localparam int N_B = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;

   logic       busy_a, done_a, lx_a, ly_a, lz_a, ld0_a, ld_a, clr_a;
   logic [1:0] sx_a, sy_a, sz_a;
   logic [3:0] iter_a;
   logic       busy_b, done_b, lx_b, ly_b, lz_b, ld0_b, ld_b, clr_b;
   logic [1:0] sx_b, sy_b, sz_b;
   logic [0:0] iter_b;

   cordic_controller #(.WORD_LENGTH(16), .ITERATIONS(N_A)) dut_a (
      .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
      .load_x(lx_a), .load_y(ly_a), .load_z(lz_a), .load_d0(ld0_a), .load_d(ld_a),
      .sel_x(sx_a), .sel_y(sy_a), .sel_z(sz_a), .clear_z(clr_a), .iter(iter_a)
   );

   cordic_controller #(.WORD_LENGTH(16), .ITERATIONS(N_B)) dut_b (
      .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
      .load_x(lx_b), .load_y(ly_b), .load_z(lz_b), .load_d0(ld0_b), .load_d(ld_b),
      .sel_x(sx_b), .sel_y(sy_b), .sel_z(sz_b), .clear_z(clr_b), .iter(iter_b)
   );

   always #5 clk = ~clk;

   logic [19:0] vec_a, vec_b;
   assign vec_a = {busy_a, done_a, lx_a, ly_a, lz_a, ld0_a, ld_a, sx_a, sy_a, sz_a, clr_a, 2'b00, iter_a};
   assign vec_b = {busy_b, done_b, lx_b, ly_b, lz_b, ld0_b, ld_b, sx_b, sy_b, sz_b, clr_b, 2'b00, 3'b000, iter_b};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs from the operation schedule: t counts cycles since start
   // was accepted (1 = load, 2 = pre-rotation, 3..n+2 = iterations, n+3 = done).
   function automatic logic [19:0] expect_vec(input bit act, input int t, input int n);
      logic [19:0] v;
      v = '0;
      if (act) begin
         if (t == 1)              v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 6'd0};
         else if (t == 2)         v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 6'd0};
         else if (t <= n + 2)     v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0, 2'b00, 4'(t - 3)};
         else                     v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 6'd0};
      end
      return v;
   endfunction

   bit m_act [2];
   int m_t   [2];
   int m_n   [2] = '{N_A, N_B};

   always @(posedge clk or negedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            m_act[k] <= 1'b0;
            m_t[k]   <= 0;
         end else if (!m_act[k]) begin
            if (start) begin
               m_act[k] <= 1'b1;
               m_t[k]   <= 1;
            end
         end else if (m_t[k] >= m_n[k] + 3) begin
            m_act[k] <= 1'b0;
         end else begin
            m_t[k] <= m_t[k] + 1;
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         c_base = 0;
   int         done_a_q[$];
   int         done_b_q[$];
   int         cnt_ld_b = 0;
   int         cnt_ld0_b = 0;
   logic       log_busy_a [64];
   logic [3:0] log_iter_a [64];
   logic [0:0] log_iter_b [64];

   always @(negedge clk) begin
      int idx;
      check("model_a", 32'(vec_a), 32'(expect_vec(m_act[0], m_t[0], N_A)));
      check("model_b", 32'(vec_b), 32'(expect_vec(m_act[1], m_t[1], N_B)));
      check("sel_not3", 32'((sx_a == 2'd3) || (sy_a == 2'd3) || (sz_a == 2'd3) ||
                            (sx_b == 2'd3) || (sy_b == 2'd3) || (sz_b == 2'd3)), 32'd0);
      check("loadz_not_in_load", 32'((lz_a && ld0_a) || (lz_b && ld0_b)), 32'd0);
      if (done_a) done_a_q.push_back(cyc);
      if (done_b) done_b_q.push_back(cyc);
      if (ld_b)  cnt_ld_b++;
      if (ld0_b) cnt_ld0_b++;
      idx = cyc - c_base;
      if (idx >= 0 && idx < 64) begin
         log_busy_a[idx] = busy_a;
         log_iter_a[idx] = iter_a;
         log_iter_b[idx] = iter_b;
      end
   end

   task automatic go_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int first_or(input int q[$], input int base);
      return (q.size() > 0) ? q[0] - base : -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int c0, c1, c2, c3;

      repeat (3) @(posedge clk);
      #1;
      check("reset_a", 32'(vec_a), 32'd0);
      check("reset_b", 32'(vec_b), 32'd0);
      rst = 1'b1;
      go_to(cyc + 2);

      // Single operation with stray starts in cycles 5 and 18.
      c0 = cyc; c_base = c0;
      done_a_q.delete(); done_b_q.delete(); cnt_ld_b = 0; cnt_ld0_b = 0;
      start = 1'b1; go_to(c0 + 1); start = 1'b0;
      go_to(c0 + 5); start = 1'b1; go_to(c0 + 6); start = 1'b0;
      check("n2_load_d_pulses", 32'(cnt_ld_b), 32'd3);
      check("n2_load_d0_pulses", 32'(cnt_ld0_b), 32'd1);
      check("n2_done_cycle", 32'(first_or(done_b_q, c0)), 32'd5);
      check("n2_iter_c3", 32'(log_iter_b[3]), 32'd0);
      check("n2_iter_c4", 32'(log_iter_b[4]), 32'd1);
      go_to(c0 + 18); start = 1'b1; go_to(c0 + 19); start = 1'b0;
      go_to(c0 + 26);
      check("s1_done_count", 32'(done_a_q.size()), 32'd1);
      check("s1_done_cycle", 32'(first_or(done_a_q, c0)), 32'd19);
      check("s1_busy_c0", 32'(log_busy_a[0]), 32'd0);
      check("s1_busy_c1", 32'(log_busy_a[1]), 32'd1);
      check("s1_busy_c18", 32'(log_busy_a[18]), 32'd1);
      check("s1_busy_c19", 32'(log_busy_a[19]), 32'd0);
      check("s1_iter_c3", 32'(log_iter_a[3]), 32'd0);
      check("s1_iter_c10", 32'(log_iter_a[10]), 32'd7);
      check("s1_iter_c18", 32'(log_iter_a[18]), 32'd15);

      // Asynchronous reset mid-operation, then a fresh operation.
      c1 = cyc; done_a_q.delete();
      start = 1'b1; go_to(c1 + 1); start = 1'b0;
      go_to(c1 + 10);
      #2 rst = 1'b0;
      #1;
      check("rst_async_a", 32'(vec_a), 32'd0);
      check("rst_async_b", 32'(vec_b), 32'd0);
      go_to(c1 + 12); rst = 1'b1;
      go_to(c1 + 14);
      check("rst_no_done", 32'(done_a_q.size()), 32'd0);
      c2 = cyc; done_a_q.delete();
      start = 1'b1; go_to(c2 + 1); start = 1'b0;
      go_to(c2 + 22);
      check("rst_restart_count", 32'(done_a_q.size()), 32'd1);
      check("rst_restart_cycle", 32'(first_or(done_a_q, c2)), 32'd19);

      // Start held high: back-to-back operations.
      c3 = cyc; done_a_q.delete();
      start = 1'b1; go_to(c3 + 60); start = 1'b0;
      go_to(c3 + 64);
      check("b2b_count", 32'(done_a_q.size()), 32'd3);
      check("b2b_done0", 32'((done_a_q.size() > 0) ? done_a_q[0] - c3 : -1), 32'd19);
      check("b2b_done1", 32'((done_a_q.size() > 1) ? done_a_q[1] - c3 : -1), 32'd39);
      check("b2b_done2", 32'((done_a_q.size() > 2) ? done_a_q[2] - c3 : -1), 32'd59);

      // Randomized start traffic with occasional mid-cycle resets.
      repeat (1500) begin
         @(posedge clk);
         #1;
         start = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 149) == 0) begin
            #2 rst = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
         end
      end
      start = 1'b0;
      go_to(cyc + 25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
